zvc_compressor128: RTL and testbench

Zero-value compressor for one 128-word input feature-map line and its mapping table. Each cycle it packs every nonzero word and its mapping-table entry toward index 0, preserving their original order, and zero-fills the remaining slots. It sits between the line buffer and the redundancy-controller datapath, so downstream logic only needs to process the dense prefix. The result is registered with a fixed one-cycle latency and is fully pipelined, accepting a new line every cycle.

---
 rtl/zvc_compressor128.sv | 52 +++++
 tb/tb_zvc_compressor128.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/zvc_compressor128.sv
// Zero-value compressor: packs the nonzero words of a 128-word line, plus their mapping-table
// entries, toward slot 0 in order. Result is registered with one cycle of latency.
module zvc_compressor128 #(
  parameter int WORD_WIDTH    = 8,
  parameter int DIST_WIDTH    = 7,
  parameter int MAX_LIFM_RSIZ = 4
) (
  input  logic                                         clk,
  input  logic                                         reset_n,
  input  logic [128*WORD_WIDTH-1:0]                    lifm_line,
  input  logic [128*DIST_WIDTH*MAX_LIFM_RSIZ-1:0]      mt_line,
  output logic [128*WORD_WIDTH-1:0]                    lifm_comp,
  output logic [128*DIST_WIDTH*MAX_LIFM_RSIZ-1:0]      mt_comp
);

  localparam int LINE = 128;
  localparam int ME   = DIST_WIDTH * MAX_LIFM_RSIZ;

  logic [WORD_WIDTH-1:0] lifm_next [LINE];
  logic [ME-1:0]         mt_next   [LINE];

  // Running count of kept words is the exclusive prefix sum d[i]; kept words never exceed
  // index 127 as a destination, so the low 7 bits address the slot.
  always_comb begin
    logic [7:0] cnt;
    cnt = '0;
    for (int s = 0; s < LINE; s++) begin
      lifm_next[s] = '0;
      mt_next[s]   = '0;
    end
    for (int i = 0; i < LINE; i++) begin
      if (lifm_line[i*WORD_WIDTH +: WORD_WIDTH] != '0) begin
        lifm_next[cnt[6:0]] = lifm_line[i*WORD_WIDTH +: WORD_WIDTH];
        mt_next[cnt[6:0]]   = mt_line[i*ME +: ME];
        cnt                 = cnt + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lifm_comp <= '0;
      mt_comp   <= '0;
    end else begin
      for (int s = 0; s < LINE; s++) begin
        lifm_comp[s*WORD_WIDTH +: WORD_WIDTH] <= lifm_next[s];
        mt_comp[s*ME +: ME]                   <= mt_next[s];
      end
    end
  end

endmodule

// File: tb/tb_zvc_compressor128.sv
// Self-checking bench for zvc_compressor128: directed vector table, randomized lines against a
// queue-based reference model, and asynchronous reset sequences.
module tb_zvc_compressor128;

  localparam int W  = 8;
  localparam int ME = 28;
  localparam int LW = 128 * W;
  localparam int MW = 128 * ME;

  typedef struct {
    string         name;
    logic [LW-1:0] lifm;
    logic [MW-1:0] mt;
    logic [LW-1:0] exp_lifm;
    logic [MW-1:0] exp_mt;
  } vec_t;

  logic          clk;
  logic          reset_n;
  logic [LW-1:0] lifm_line;
  logic [MW-1:0] mt_line;
  logic [LW-1:0] lifm_comp;
  logic [MW-1:0] mt_comp;

  int n_assert = 0;
  int n_fail   = 0;
  vec_t vecs[$];

  zvc_compressor128 dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .lifm_line (lifm_line),
    .mt_line   (mt_line),
    .lifm_comp (lifm_comp),
    .mt_comp   (mt_comp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [LW-1:0] put_w(input logic [LW-1:0] v, input int i, input logic [W-1:0] x);
    logic [LW-1:0] r;
    r = v;
    r[i*W +: W] = x;
    return r;
  endfunction

  function automatic logic [MW-1:0] put_m(input logic [MW-1:0] v, input int i, input logic [ME-1:0] x);
    logic [MW-1:0] r;
    r = v;
    r[i*ME +: ME] = x;
    return r;
  endfunction

  // Reference: gather kept (word, entry) pairs in order, then lay them out from slot 0.
  function automatic void model(input logic [LW-1:0] l, input logic [MW-1:0] m,
                                output logic [LW-1:0] el, output logic [MW-1:0] em);
    logic [W-1:0]  qw[$];
    logic [ME-1:0] qm[$];
    for (int i = 0; i < 128; i++)
      if (l[i*W +: W] != 0) begin
        qw.push_back(l[i*W +: W]);
        qm.push_back(m[i*ME +: ME]);
      end
    el = '0;
    em = '0;
    foreach (qw[s]) begin
      el[s*W +: W]   = qw[s];
      em[s*ME +: ME] = qm[s];
    end
  endfunction

  task automatic check(input string nm, input logic [LW-1:0] el, input logic [MW-1:0] em);
    n_assert++;
    if (lifm_comp !== el) begin
      n_fail++;
      for (int s = 0; s < 128; s++)
        if (lifm_comp[s*W +: W] !== el[s*W +: W]) begin
          $display("FAIL %s lifm_comp slot %0d actual=%h required=%h", nm, s,
                   lifm_comp[s*W +: W], el[s*W +: W]);
          break;
        end
    end
    n_assert++;
    if (mt_comp !== em) begin
      n_fail++;
      for (int s = 0; s < 128; s++)
        if (mt_comp[s*ME +: ME] !== em[s*ME +: ME]) begin
          $display("FAIL %s mt_comp slot %0d actual=%h required=%h", nm, s,
                   mt_comp[s*ME +: ME], em[s*ME +: ME]);
          break;
        end
    end
  endtask

  task automatic randomize_inputs();
    for (int i = 0; i < 128; i++) begin
      lifm_line[i*W +: W]  = W'($urandom());
      mt_line[i*ME +: ME] = ME'($urandom());
    end
  endtask

  // Drive one vector per negedge and check the previous one, so results land back to back.
  task automatic run_stream();
    for (int k = 0; k <= vecs.size(); k++) begin
      @(negedge clk);
      if (k > 0) check(vecs[k-1].name, vecs[k-1].exp_lifm, vecs[k-1].exp_mt);
      if (k < vecs.size()) begin
        lifm_line = vecs[k].lifm;
        mt_line   = vecs[k].mt;
      end
    end
  endtask

  initial begin
    vec_t v;
    logic [LW-1:0] el;
    logic [MW-1:0] em;
    reset_n = 1'b1;
    randomize_inputs();

    // Reset asserted between edges forces zero immediately and holds it.
    #1 reset_n = 1'b0;
    #1 check("reset_async", '0, '0);
    @(negedge clk);
    check("reset_hold", '0, '0);
    @(negedge clk);
    check("reset_hold2", '0, '0);
    reset_n = 1'b1;

    // Directed table with hand-derived expectations.
    v = '{name: "sparse", lifm: '0, mt: '0, exp_lifm: '0, exp_mt: '0};
    v.lifm = put_w(v.lifm, 3, 8'd13);
    v.lifm = put_w(v.lifm, 8, 8'd47);
    v.lifm = put_w(v.lifm, 15, 8'd22);
    v.mt = put_m(v.mt, 3, 28'd1);
    v.mt = put_m(v.mt, 8, 28'd1);
    v.mt = put_m(v.mt, 15, 28'd1);
    v.exp_lifm = put_w(v.exp_lifm, 0, 8'd13);
    v.exp_lifm = put_w(v.exp_lifm, 1, 8'd47);
    v.exp_lifm = put_w(v.exp_lifm, 2, 8'd22);
    for (int s = 0; s < 3; s++) v.exp_mt = put_m(v.exp_mt, s, 28'd1);
    vecs.push_back(v);

    v = '{name: "order", lifm: '0, mt: '0, exp_lifm: '0, exp_mt: '0};
    v.lifm = put_w(v.lifm, 5, 8'd15);
    v.lifm = put_w(v.lifm, 32, 8'd74);
    v.lifm = put_w(v.lifm, 75, 8'd35);
    v.mt = put_m(v.mt, 5, 28'd1);
    v.mt = put_m(v.mt, 32, 28'd1);
    v.mt = put_m(v.mt, 75, 28'd1);
    v.exp_lifm = put_w(v.exp_lifm, 0, 8'd15);
    v.exp_lifm = put_w(v.exp_lifm, 1, 8'd74);
    v.exp_lifm = put_w(v.exp_lifm, 2, 8'd35);
    for (int s = 0; s < 3; s++) v.exp_mt = put_m(v.exp_mt, s, 28'd1);
    vecs.push_back(v);

    v = '{name: "all_zero_orphan_mt", lifm: '0, mt: '0, exp_lifm: '0, exp_mt: '0};
    v.mt = put_m(v.mt, 10, 28'd5);
    vecs.push_back(v);

    v = '{name: "dense", lifm: '0, mt: '0, exp_lifm: '0, exp_mt: '0};
    for (int i = 0; i < 128; i++) begin
      v.lifm = put_w(v.lifm, i, 8'(i + 1));
      v.mt   = put_m(v.mt, i, 28'(i));
    end
    v.exp_lifm = v.lifm;
    v.exp_mt   = v.mt;
    vecs.push_back(v);

    v = '{name: "edge_slot127", lifm: '0, mt: '0, exp_lifm: '0, exp_mt: '0};
    v.lifm = put_w(v.lifm, 127, 8'd255);
    v.mt   = put_m(v.mt, 127, 28'h3FFF);
    v.exp_lifm = put_w(v.exp_lifm, 0, 8'd255);
    v.exp_mt   = put_m(v.exp_mt, 0, 28'h3FFF);
    vecs.push_back(v);

    run_stream();

    // Randomized lines of varying density; mt entries always random so orphans get dropped.
    vecs.delete();
    for (int n = 0; n < 150; n++) begin
      int dens;
      dens = (n % 10 == 0) ? 0 : (n % 10 == 1) ? 100 : int'($urandom_range(1, 99));
      v.name = $sformatf("rand%0d", n);
      for (int i = 0; i < 128; i++) begin
        v.lifm[i*W +: W]  = ($urandom_range(1, 100) <= dens) ? W'($urandom_range(1, 255)) : '0;
        v.mt[i*ME +: ME] = ME'($urandom());
      end
      model(v.lifm, v.mt, el, em);
      v.exp_lifm = el;
      v.exp_mt   = em;
      vecs.push_back(v);
    end
    run_stream();

    // Mid-stream reset discards the registered result; first edge after release samples normally.
    @(negedge clk);
    randomize_inputs();
    model(lifm_line, mt_line, el, em);
    @(negedge clk);
    check("pre_reset_line", el, em);
    #2 reset_n = 1'b0;
    #1 check("midstream_reset_async", '0, '0);
    randomize_inputs();
    @(negedge clk);
    check("midstream_reset_hold", '0, '0);
    reset_n = 1'b1;
    model(lifm_line, mt_line, el, em);
    @(negedge clk);
    check("first_edge_after_reset", el, em);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
